// File: rtl/program_mem_pkg.sv
// ----------------------------------------------------------------------------
// program_mem_pkg
//
// Purpose:
//   Shared definitions for the Jac1-8 instruction memory. This package holds
//   the default geometry of the program ROM, the instruction word type, the
//   NOP encoding and the fixed program image. The image is a constant array
//   so that CPU-level benches can reuse it.
//
// Contents:
//   PC_WIDTH      - default width of the program-counter address
//   DataWidth     - default width of one instruction word
//   CMD_CNT       - number of implemented ROM words (addresses 0..CMD_CNT-1)
//   ROM_ADDR_W    - address bits needed to index the implemented words
//   word_t        - instruction word type
//   NOP           - all-zero instruction returned for empty/out-of-range words
//   PROGRAM_IMAGE - the program, one entry per implemented address
// ----------------------------------------------------------------------------
`timescale 1ns/1ps

package program_mem_pkg;

    localparam int PC_WIDTH   = 8;
    localparam int DataWidth  = 16;
    localparam int CMD_CNT    = 64;
    localparam int ROM_ADDR_W = $clog2(CMD_CNT);

    typedef logic [DataWidth-1:0] word_t;

    localparam word_t NOP = 16'h0000;

    // Program image, eight words per line, address 0 first.
    localparam word_t PROGRAM_IMAGE [CMD_CNT] = '{
        16'h4903, 16'h4A14, 16'h4BF0, 16'h0910, 16'h1918, 16'h480F, 16'h2008, 16'h2918,
        16'h3308, 16'h1308, 16'h8802, 16'h0000, 16'h0000, 16'h3902, 16'h4204, 16'h9003,
        16'h0000, 16'h0000, 16'h0000, 16'h1210, 16'h8801, 16'h0000, 16'h9801, 16'h0000,
        16'h0910, 16'h9801, 16'h0000, 16'h5100, 16'hA001, 16'h5008, 16'hA001, 16'h0000,
        16'h8008, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
        16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
        16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
        16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000
    };

endpackage

// File: rtl/program_rom.sv
// ----------------------------------------------------------------------------
// program_rom
//
// Purpose:
//   Purely combinational lookup from a program-counter value to the
//   instruction word stored at that address. Addresses at or beyond the
//   implemented depth return NOP; there is no wrap-around.
//
// Ports:
//   addr - instruction address (PC_WIDTH bits)
//   word - instruction word at addr, or NOP when addr is out of range
// ----------------------------------------------------------------------------
`timescale 1ns/1ps

module program_rom
    import program_mem_pkg::*;
#(
    parameter int PC_WIDTH  = program_mem_pkg::PC_WIDTH,
    parameter int DataWidth = program_mem_pkg::DataWidth,
    parameter int CMD_CNT   = program_mem_pkg::CMD_CNT
) (
    input  logic [PC_WIDTH-1:0]  addr,
    output logic [DataWidth-1:0] word
);

    // The address is widened to 32 bits so the range check compares
    // like-sized operands whatever PC_WIDTH is chosen.
    logic [31:0]           addr_ext;
    logic                  in_range;
    logic [ROM_ADDR_W-1:0] rom_index;

    assign addr_ext  = 32'(addr);
    assign in_range  = (addr_ext < 32'(CMD_CNT));
    assign rom_index = addr_ext[ROM_ADDR_W-1:0];

    // Only the low index bits select a word; the upper bits are consulted
    // solely through in_range, which forces NOP for unimplemented addresses.
    always_comb begin
        word = DataWidth'(NOP);
        if (in_range) begin
            word = DataWidth'(PROGRAM_IMAGE[rom_index]);
        end
    end

endmodule

// File: rtl/program_mem.sv
// ----------------------------------------------------------------------------
// program_mem
//
// Purpose:
//   Read-only instruction memory for the Jac1-8 CPU. The program counter is
//   sampled on each rising clock edge and the addressed instruction word is
//   presented on ir one edge later. The lookup itself is combinational; only
//   the output register is clocked. An active-low asynchronous reset clears
//   ir to NOP immediately.
//
// Ports:
//   clk   - system clock, rising-edge active
//   res_n - asynchronous active-low reset
//   pc    - instruction address (PC_WIDTH bits)
//   ir    - registered instruction word (DataWidth bits)
// ----------------------------------------------------------------------------
`timescale 1ns/1ps

module program_mem
    import program_mem_pkg::*;
#(
    parameter int PC_WIDTH  = program_mem_pkg::PC_WIDTH,
    parameter int DataWidth = program_mem_pkg::DataWidth,
    parameter int CMD_CNT   = program_mem_pkg::CMD_CNT
) (
    input  logic                 clk,
    input  logic                 res_n,
    input  logic [PC_WIDTH-1:0]  pc,
    output logic [DataWidth-1:0] ir
);

    logic [DataWidth-1:0] rom_word;
    logic [DataWidth-1:0] ir_d;
    logic [DataWidth-1:0] ir_q;

    program_rom #(
        .PC_WIDTH  (PC_WIDTH),
        .DataWidth (DataWidth),
        .CMD_CNT   (CMD_CNT)
    ) u_program_rom (
        .addr (pc),
        .word (rom_word)
    );

    always_comb begin
        ir_d = rom_word;
    end

    // Reset clears the instruction register without waiting for a clock so
    // the decoder sees a NOP as soon as the CPU is held in reset.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            ir_q <= DataWidth'(NOP);
        end else begin
            ir_q <= ir_d;
        end
    end

    assign ir = ir_q;

endmodule

// File: tb/tb_program_mem.sv
// ----------------------------------------------------------------------------
// tb_program_mem
//
// Purpose:
//   Self-checking bench for program_mem. Each address driven onto pc has its
//   expected instruction word pushed onto a scoreboard queue; after the next
//   rising edge the DUT output is compared against the popped entry. The
//   expected words come from an independent reference table in this file.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_program_mem;

    logic        clk;
    logic        res_n;
    logic [7:0]  pc;
    logic [15:0] ir;

    int check_count;
    int pass_count;

    logic [15:0] exp_queue [$];

    program_mem dut (
        .clk   (clk),
        .res_n (res_n),
        .pc    (pc),
        .ir    (ir)
    );

    // 10 ns clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference program image, written out as the expected fetch results.
    function automatic logic [15:0] refWord(input logic [7:0] addr);
        logic [15:0] w;
        case (addr)
            8'd0:    w = 16'h4903;
            8'd1:    w = 16'h4A14;
            8'd2:    w = 16'h4BF0;
            8'd3:    w = 16'h0910;
            8'd4:    w = 16'h1918;
            8'd5:    w = 16'h480F;
            8'd6:    w = 16'h2008;
            8'd7:    w = 16'h2918;
            8'd8:    w = 16'h3308;
            8'd9:    w = 16'h1308;
            8'd10:   w = 16'h8802;
            8'd13:   w = 16'h3902;
            8'd14:   w = 16'h4204;
            8'd15:   w = 16'h9003;
            8'd19:   w = 16'h1210;
            8'd20:   w = 16'h8801;
            8'd22:   w = 16'h9801;
            8'd24:   w = 16'h0910;
            8'd25:   w = 16'h9801;
            8'd27:   w = 16'h5100;
            8'd28:   w = 16'hA001;
            8'd29:   w = 16'h5008;
            8'd30:   w = 16'hA001;
            8'd32:   w = 16'h8008;
            default: w = 16'h0000;
        endcase
        return w;
    endfunction

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        check_count++;
        if (observed === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: ir=%h expected=%h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Pops the oldest scoreboard entry and compares it with ir.
    task automatic popAndCheck(input string tag);
        logic [15:0] expected;
        if (exp_queue.size() == 0) begin
            check_count++;
            $display("[TB] FAIL %s: scoreboard empty, ir=%h expected=<entry>", tag, ir);
        end else begin
            expected = exp_queue.pop_front();
            checkOutput(tag, ir, expected);
        end
    endtask

    // Drives pc between edges, records the expected word, then samples ir
    // 6 ns after the following rising edge.
    task automatic applyStimulus(input logic [7:0] addr, input string tag);
        pc = addr;
        exp_queue.push_back(refWord(addr));
        @(posedge clk);
        #6;
        popAndCheck($sformatf("%s pc=%0d", tag, addr));
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached, ir=%h expected=finish", ir);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int zero_addrs [] = '{11, 12, 16, 17, 18, 21, 23, 26, 31, 33, 63};
        int oor_addrs  [] = '{64, 128, 255};

        check_count = 0;
        pass_count  = 0;
        res_n       = 1'b0;
        pc          = 8'd0;

        // Reset held across several edges: ir must stay zero.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #6;
            checkOutput($sformatf("reset hold %0d", i), ir, 16'h0000);
        end

        // Release between edges: still zero until the next rising edge.
        res_n = 1'b1;
        #1;
        checkOutput("after release before edge", ir, 16'h0000);
        pc = 8'd0;
        exp_queue.push_back(refWord(8'd0));
        @(posedge clk);
        #6;
        popAndCheck("first fetch after release");

        // Sequential fetch through the populated part of the image.
        for (int a = 0; a <= 32; a++) begin
            applyStimulus(8'(a), "seq");
        end

        // Zero-filled addresses inside the implemented range.
        foreach (zero_addrs[i]) begin
            applyStimulus(8'(zero_addrs[i]), "zero");
        end

        // Addresses past the implemented depth read as NOP.
        foreach (oor_addrs[i]) begin
            applyStimulus(8'(oor_addrs[i]), "oor");
        end

        // pc changes mid-cycle must not reach ir before the next edge.
        applyStimulus(8'd5, "latency setup");
        pc = 8'd6;
        exp_queue.push_back(refWord(8'd6));
        #2;
        checkOutput("latency hold", ir, 16'h480F);
        @(posedge clk);
        #6;
        popAndCheck("latency update pc=6");

        // Asynchronous reset in the middle of a run.
        applyStimulus(8'd10, "async setup");
        res_n = 1'b0;
        #1;
        checkOutput("async clear", ir, 16'h0000);
        res_n = 1'b1;
        #1;
        checkOutput("async released no edge", ir, 16'h0000);
        exp_queue.push_back(refWord(8'd10));
        @(posedge clk);
        #6;
        popAndCheck("async refetch pc=10");

        if (exp_queue.size() != 0) begin
            check_count++;
            $display("[TB] FAIL scoreboard drain: leftover=%0d expected=0", exp_queue.size());
        end

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
